// File: rtl/seq_detect_moore_if.sv
// Serial-bit detector bus: data/valid/clear from the source, match pulse and count back.
// The master modport belongs to the stimulus side and the slave modport to the detector.
interface seq_detect_moore_if #(
  parameter int CNT_W = 8
);
  logic             inbits;
  logic             in_valid;
  logic             count_clr;
  logic             out;
  logic [CNT_W-1:0] match_count;

  modport master (
    output inbits, in_valid, count_clr,
    input  out, match_count
  );

  modport slave (
    input  inbits, in_valid, count_clr,
    output out, match_count
  );
endinterface

// File: rtl/seq_detect_moore.sv
// Moore serial pattern detector: a history shift register plus a saturating fill count, with a registered match pulse.
// Defining SEQ_DETECT_MATCH_CNT_EN compiles in the saturating match counter and count_clr; otherwise match_count is tied to 0.
module seq_detect_moore #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input logic               clk,
  input logic               reset,
  seq_detect_moore_if.slave bus
);
  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              out_q;
  logic              match;

  // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    match  = 1'b0;
    if (bus.in_valid) begin
      hist_d = {hist_q[PAT_W-2:0], bus.inbits};
      fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
      match  = (fill_d == FILL_FULL) && (hist_d == PATTERN);
      // Non-overlapping mode forces the next match to be built from PAT_W fresh bits.
      if (match && !OVERLAP) begin
        fill_d = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= match;
    end
  end

  assign bus.out = out_q;

`ifdef SEQ_DETECT_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Clear wins over a coincident match; the count holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (bus.count_clr) begin
      cnt_q <= '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.match_count = cnt_q;
`else
  logic unused_count_clr;

  assign unused_count_clr = bus.count_clr;
  assign bus.match_count  = '0;
`endif
endmodule

// File: tb/tb_seq_detect_moore.sv
// Directed bench for seq_detect_moore: three detectors (overlap, non-overlap, 2-bit counter) share one input stream.
// Count expectations follow SEQ_DETECT_MATCH_CNT_EN; with it undefined every match_count is expected to read 0.
module tb_seq_detect_moore;
`ifdef SEQ_DETECT_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic inbits;
  logic in_valid;
  logic count_clr;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  seq_detect_moore_if #(.CNT_W(8)) if_ov  ();
  seq_detect_moore_if #(.CNT_W(8)) if_no  ();
  seq_detect_moore_if #(.CNT_W(2)) if_sat ();

  assign if_ov.inbits     = inbits;
  assign if_ov.in_valid   = in_valid;
  assign if_ov.count_clr  = count_clr;
  assign if_no.inbits     = inbits;
  assign if_no.in_valid   = in_valid;
  assign if_no.count_clr  = count_clr;
  assign if_sat.inbits    = inbits;
  assign if_sat.in_valid  = in_valid;
  assign if_sat.count_clr = count_clr;

  seq_detect_moore #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .reset(reset), .bus(if_ov.slave));
  seq_detect_moore #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
    .clk(clk), .reset(reset), .bus(if_no.slave));
  seq_detect_moore #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .bus(if_sat.slave));

  function automatic logic [31:0] ec(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic v, input logic clr);
    @(negedge clk);
    inbits    = b;
    in_valid  = v;
    count_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_ov, input logic e_no, input logic e_sat);
    check({tag, "_out_ov"},  32'(if_ov.out),  32'(e_ov));
    check({tag, "_out_no"},  32'(if_no.out),  32'(e_no));
    check({tag, "_out_sat"}, 32'(if_sat.out), 32'(e_sat));
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    in_valid  = 1'b0;
    count_clr = 1'b0;
    reset     = 1'b1;
    #1;
    check({tag, "_async_out"}, 32'(if_ov.out), 32'd0);
    check({tag, "_async_cnt"}, 32'(if_ov.match_count), 32'd0);
    check({tag, "_async_cnt_sat"}, 32'(if_sat.match_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    inbits    = 1'b0;
    in_valid  = 1'b0;
    count_clr = 1'b0;
    #1;
    check("rst_init_out", 32'(if_ov.out), 32'd0);
    check("rst_init_cnt", 32'(if_ov.match_count), 32'd0);

    // Pattern bits offered while reset is held must be ignored.
    step(1'b1, 1'b1, 1'b0);
    check("rst_hold1_out", 32'(if_ov.out), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    check("rst_hold2_out", 32'(if_ov.out), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    check("rst_hold3_out", 32'(if_ov.out), 32'd0);
    check("rst_hold3_cnt", 32'(if_ov.match_count), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;

    // Single match 1,0,1,1 from an empty history.
    step(1'b1, 1'b1, 1'b0);
    check_outs("single_b1", 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_outs("single_b2", 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_outs("single_b3", 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_outs("single_b4", 1'b1, 1'b1, 1'b1);
    check("single_cnt_ov", 32'(if_ov.match_count), ec(1));
    step(1'b0, 1'b0, 1'b0);
    check_outs("single_idle", 1'b0, 1'b0, 1'b0);
    check("single_idle_cnt", 32'(if_ov.match_count), ec(1));

    // Continue the stream to 1,0,1,1,0,1,1: only the overlapping detector fires again.
    step(1'b0, 1'b1, 1'b0);
    check_outs("ovl_b5", 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_outs("ovl_b6", 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_outs("ovl_b7", 1'b1, 1'b0, 1'b1);
    check("ovl_cnt_ov", 32'(if_ov.match_count), ec(2));
    check("ovl_cnt_no", 32'(if_no.match_count), ec(1));
    step(1'b0, 1'b0, 1'b0);
    check_outs("ovl_idle", 1'b0, 1'b0, 1'b0);

    // Valid gap: 1,0, three idle cycles with inbits=1, then 1,1.
    pulse_reset("gap_rst");
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_outs("gap_pre", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check_outs("gap_idle", 1'b0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0);
    check_outs("gap_b3", 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_outs("gap_b4", 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check_outs("gap_idle_post", 1'b0, 1'b0, 1'b0);
    check("gap_cnt_ov", 32'(if_ov.match_count), ec(1));

    // Four more overlapping matches: the 2-bit counter saturates at 3.
    for (int g = 0; g < 4; g++) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      check("sat_out_ov", 32'(if_ov.out), 32'd1);
      check("sat_cnt_sat", 32'(if_sat.match_count), ec((g + 2 > 3) ? 3 : g + 2));
    end
    check("sat_cnt_ov", 32'(if_ov.match_count), ec(5));
    check("sat_cnt_no", 32'(if_no.match_count), ec(3));

    // Clear on a match edge: clear wins, out still pulses, history untouched.
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check_outs("clr_match", 1'b1, 1'b0, 1'b1);
    check("clr_cnt_ov",  32'(if_ov.match_count),  32'd0);
    check("clr_cnt_no",  32'(if_no.match_count),  32'd0);
    check("clr_cnt_sat", 32'(if_sat.match_count), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    check_outs("clr_after_b1", 1'b0, 1'b0, 1'b0);
    check("clr_after_cnt", 32'(if_ov.match_count), ec(0));
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_outs("clr_after_match", 1'b1, 1'b1, 1'b1);
    check("clr_after_cnt_ov", 32'(if_ov.match_count), ec(1));
    check("clr_after_cnt_no", 32'(if_no.match_count), ec(1));

    // Reset after 1,0,1 discards progress; the next 1 must not complete a match.
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    pulse_reset("mid_rst");
    step(1'b1, 1'b1, 1'b0);
    check_outs("mid_b1", 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_outs("mid_b3", 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check_outs("mid_b4", 1'b1, 1'b1, 1'b1);
    check("mid_cnt_ov",  32'(if_ov.match_count),  ec(1));
    check("mid_cnt_sat", 32'(if_sat.match_count), ec(1));
    step(1'b0, 1'b0, 1'b0);
    check_outs("mid_idle", 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/seq_detect_moore.md
SEQ_DETECT_MOORE -- requirements
Module: seq_detect_moore

Interface
REQ-001 The block SHALL have parameter PAT_W, default 4: pattern length in bits, legal range 2..16.
REQ-002 The block SHALL have parameter PATTERN, default 4'b1011: target sequence, PAT_W bits wide; the MSB is the oldest bit.
REQ-003 The block SHALL have parameter OVERLAP, default 1: 1 means overlapping matches are allowed, 0 means non-overlapping.
REQ-004 The block SHALL have parameter CNT_W, default 8: match counter width, legal range 1..32.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port inbits, input, 1 bit: serial data bit.
REQ-008 The block SHALL have port in_valid, input, 1 bit: inbits is accepted at a rising clk edge only when in_valid=1.
REQ-009 The block SHALL have port count_clr, input, 1 bit: synchronous clear of match_count.
REQ-010 The block SHALL have port out, output, 1 bit: registered match pulse.
REQ-011 The block SHALL have port match_count, output, CNT_W bits: number of matches since reset or clear.

Function
REQ-012 The state SHALL be a PAT_W-bit history shift register plus a fill counter FILL (0..PAT_W, saturating) giving the number of valid history bits.
REQ-013 On an accepted bit, the block SHALL shift inbits into the history LSB and increment FILL, saturating at PAT_W.
REQ-014 A match SHALL occur at an accepting edge when the next FILL equals PAT_W and the next history equals PATTERN.
REQ-015 out SHALL be registered and depend only on flops: out=1 for exactly one cycle following the edge that accepted the final pattern bit (latency 1 clock), otherwise out=0.
REQ-016 When in_valid=0, the history and FILL SHALL hold, and out SHALL be 0 after that edge.
REQ-017 With OVERLAP=1, FILL SHALL remain at PAT_W after a match, so a match's trailing bits may begin the next match.
REQ-018 With OVERLAP=0, the edge that produces a match SHALL set FILL to 0, so the next match needs PAT_W fresh accepted bits.
REQ-019 With CNT_W-bit saturating arithmetic, each match SHALL increment match_count, holding at all-ones with no wrap-around.
REQ-020 When count_clr=1, match_count SHALL become 0 at that edge; if a match occurs on the same edge, the clear SHALL win and match_count=0, while out still pulses.
REQ-021 count_clr SHALL NOT affect the history, FILL or out.

Reset
REQ-022 While reset=1, the block SHALL immediately and asynchronously force history=0, FILL=0, out=0 and match_count=0, regardless of clk.
REQ-023 A reset asserted mid-pattern SHALL discard all partial progress; no match SHALL be produced from bits accepted before reset.
REQ-024 After reset deasserts, the first accepted bit SHALL be at the first rising clk edge at which reset=0 and in_valid=1.

Configuration
REQ-025 When macro SEQ_DETECT_MATCH_CNT_EN is defined, the saturating counter and count_clr behaviour SHALL be compiled in as specified.
REQ-026 When SEQ_DETECT_MATCH_CNT_EN is not defined, match_count SHALL be a constant 0, count_clr SHALL be ignored, and no counter flops SHALL exist; out behaviour SHALL be unchanged.

Verification (defaults PAT_W=4, PATTERN=1011, macro defined unless noted)
REQ-027 Reset test: hold reset=1 for 3 clocks with in_valid=1 and pattern bits applied -> out=0 and match_count=0 throughout.
REQ-028 Single match test: in_valid=1 with bits 1,0,1,1 -> out=1 in the cycle after the 4th edge only, then match_count=1.
REQ-029 Overlap test: with OVERLAP=1 and stream 1,0,1,1,0,1,1 -> out pulses after bits 4 and 7 and match_count=2; with OVERLAP=0 and the same stream -> one pulse and match_count=1.
REQ-030 Valid-gap test: bits 1,0, then in_valid=0 for 3 cycles, then 1,1 -> exactly one out pulse after the final bit, with out=0 during the gap.
REQ-031 Saturation and clear test: with CNT_W=2 and 5 overlapping matches -> match_count=3 held; then count_clr=1 on a match edge -> match_count=0 and out=1.
REQ-032 Mid-reset and macro-off test: reset pulsed after bits 1,0,1, then bit 1 -> no pulse; with the macro undefined, repeat REQ-028 -> out identical and match_count=0.
